// File: rtl/uart_alu_ctrl.sv
// Sequencer that gathers operand A, operand B and opcode bytes from the UART receiver,
// presents them to the ALU, and hands the captured result to the UART transmitter.
module uart_alu_ctrl #(
    parameter int NBIT_DATA = 8,
    parameter int NBIT_OP   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    input  logic [NBIT_DATA-1:0] rx_data,
    input  logic [NBIT_DATA-1:0] alu_result,
    input  logic                 tx_done_tick,
    output logic [NBIT_DATA-1:0] alu_a,
    output logic [NBIT_DATA-1:0] alu_b,
    output logic [NBIT_OP-1:0]   alu_op,
    output logic                 tx_start,
    output logic [NBIT_DATA-1:0] tx_data,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic                 rx_q_r;
    logic                 done_q_r;
    logic                 rx_rise_s;
    logic                 done_rise_s;
    logic [NBIT_DATA-1:0] alu_a_r;
    logic [NBIT_DATA-1:0] alu_a_next_s;
    logic [NBIT_DATA-1:0] alu_b_r;
    logic [NBIT_DATA-1:0] alu_b_next_s;
    logic [NBIT_OP-1:0]   alu_op_r;
    logic [NBIT_OP-1:0]   alu_op_next_s;
    logic [NBIT_DATA-1:0] tx_data_r;
    logic [NBIT_DATA-1:0] tx_data_next_s;
    logic                 tx_start_r;
    logic                 tx_start_next_s;
    logic                 busy_r;
    logic                 busy_next_s;
    logic                 overrun_r;
    logic                 overrun_next_s;

    // Both handshake inputs are levels; only their rising edges are events.
    assign rx_rise_s   = rx_done_tick & ~rx_q_r;
    assign done_rise_s = tx_done_tick & ~done_q_r;

    // Next-state and next-register computation for the byte-collect / execute / send sequence.
    always_comb begin
        state_next_s    = state_r;
        alu_a_next_s    = alu_a_r;
        alu_b_next_s    = alu_b_r;
        alu_op_next_s   = alu_op_r;
        tx_data_next_s  = tx_data_r;
        tx_start_next_s = tx_start_r;
        overrun_next_s  = overrun_r;

        case (state_r)
            WAIT_A: begin
                if (rx_rise_s) begin
                    alu_a_next_s = rx_data;
                    state_next_s = WAIT_B;
                end else begin
                    state_next_s = WAIT_A;
                end
            end
            WAIT_B: begin
                if (rx_rise_s) begin
                    alu_b_next_s = rx_data;
                    state_next_s = WAIT_OP;
                end else begin
                    state_next_s = WAIT_B;
                end
            end
            WAIT_OP: begin
                if (rx_rise_s) begin
                    alu_op_next_s = rx_data[NBIT_OP-1:0];
                    state_next_s  = EXEC;
                end else begin
                    state_next_s = WAIT_OP;
                end
            end
            EXEC: begin
                // Operands have been stable for a full cycle, so the ALU output is settled.
                tx_data_next_s  = alu_result;
                tx_start_next_s = 1'b1;
                state_next_s    = SEND;
                if (rx_rise_s) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            SEND: begin
                if (done_rise_s) begin
                    tx_start_next_s = 1'b0;
                    state_next_s    = WAIT_A;
                end else begin
                    tx_start_next_s = 1'b1;
                    state_next_s    = SEND;
                end
                if (rx_rise_s) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            default: begin
                tx_start_next_s = 1'b0;
                state_next_s    = WAIT_A;
            end
        endcase

        busy_next_s = (state_next_s != WAIT_A);
    end

    // State, datapath and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= WAIT_A;
            rx_q_r     <= 1'b0;
            done_q_r   <= 1'b0;
            alu_a_r    <= {NBIT_DATA{1'b0}};
            alu_b_r    <= {NBIT_DATA{1'b0}};
            alu_op_r   <= {NBIT_OP{1'b0}};
            tx_data_r  <= {NBIT_DATA{1'b0}};
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            rx_q_r     <= rx_done_tick;
            done_q_r   <= tx_done_tick;
            alu_a_r    <= alu_a_next_s;
            alu_b_r    <= alu_b_next_s;
            alu_op_r   <= alu_op_next_s;
            tx_data_r  <= tx_data_next_s;
            tx_start_r <= tx_start_next_s;
            busy_r     <= busy_next_s;
            overrun_r  <= overrun_next_s;
        end
    end

    assign alu_a    = alu_a_r;
    assign alu_b    = alu_b_r;
    assign alu_op   = alu_op_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed byte sequences, a behavioural ALU and TX handshake,
// and a scoreboard monitor that checks every frame the controller launches.
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [7:0] alu_result;
    logic       tx_done_tick;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    int         frames = 0;
    int         exp_frames = 0;
    logic [7:0] exp_q[$];

    uart_alu_ctrl #(.NBIT_DATA(8), .NBIT_OP(6)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .alu_result(alu_result), .tx_done_tick(tx_done_tick), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b;
            6'h03:   return $unsigned($signed(a) >>> b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each new tx_start rise is one frame request.
    logic       tx_start_q = 1'b0;
    logic [7:0] held_data = 8'h00;
    always @(negedge clk) begin
        if (tx_start === 1'b1 && tx_start_q !== 1'b1) begin
            frames++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got tx_data 0x%0h expected no frame", tx_data);
            end else begin
                check("frame_data", tx_data, exp_q.pop_front());
            end
            held_data = tx_data;
        end else if (tx_start === 1'b1) begin
            check("tx_data_stable", tx_data, held_data);
        end
        tx_start_q = tx_start;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] exp);
        exp_q.push_back(exp);
        exp_frames++;
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    task automatic wait_tx_start();
        int n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", tx_start, 1);
    endtask

    task automatic serve_tx(input int hold);
        wait_tx_start();
        repeat (2) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        check("tx_start_drop", tx_start, 0);
        check("busy_after_done", busy, 0);
        repeat (hold - 1) @(negedge clk);
        check("tx_start_stays_low", tx_start, 0);
        tx_done_tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        tx_done_tick = 1'b0;
        #1;
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_tx_data", tx_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic ADD with latency check: tx_start rises on the second edge after the opcode.
        send_byte(8'h05);
        check("basic_alu_a", alu_a, 8'h05);
        check("basic_busy", busy, 1);
        send_byte(8'h03);
        check("basic_alu_b", alu_b, 8'h03);
        exp_q.push_back(8'h08);
        exp_frames++;
        send_byte(8'h20);
        check("basic_alu_op", alu_op, 6'h20);
        check("latency_one_edge", tx_start, 0);
        @(negedge clk);
        check("latency_two_edges", tx_start, 1);
        check("basic_tx_data", tx_data, 8'h08);

        // Done level held 16 cycles: one frame only.
        serve_tx(16);
        check("one_frame", frames, 1);

        // Overrun during SEND; a byte is dropped but the next sequence is fine.
        send_seq(8'h10, 8'h20, 8'h22, 8'hF0);
        send_byte(8'h77);
        check("ovr_flag", overrun, 1);
        check("ovr_alu_a", alu_a, 8'h10);
        check("ovr_tx_data", tx_data, 8'hF0);
        check("ovr_tx_start", tx_start, 1);
        serve_tx(3);
        send_seq(8'h01, 8'h01, 8'h20, 8'h02);
        serve_tx(2);
        check("ovr_sticky", overrun, 1);

        // RX level held 20 cycles loads only operand A; stray done in WAIT_B is ignored.
        @(negedge clk);
        rx_data      = 8'hAA;
        rx_done_tick = 1'b1;
        repeat (20) @(negedge clk);
        check("level_alu_a", alu_a, 8'hAA);
        check("level_alu_b", alu_b, 8'h01);
        check("level_busy", busy, 1);
        rx_done_tick = 1'b0;
        @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        @(negedge clk);
        check("stray_busy", busy, 1);
        check("stray_tx_start", tx_start, 0);
        send_byte(8'h05);
        check("stray_alu_b", alu_b, 8'h05);
        check("stray_alu_a", alu_a, 8'hAA);
        exp_q.push_back(8'hAF);
        exp_frames++;
        send_byte(8'hE0);
        check("op_truncated", alu_op, 6'h20);
        serve_tx(4);

        // Back-to-back sequences, results must arrive in order.
        send_seq(8'h0F, 8'h33, 8'h24, 8'h03);
        serve_tx(1);
        send_seq(8'h0F, 8'h33, 8'h26, 8'h3C);
        serve_tx(1);

        // Byte and done rise in the same SEND cycle: done wins, byte dropped.
        send_seq(8'h80, 8'h01, 8'h02, 8'h40);
        wait_tx_start();
        @(negedge clk);
        rx_data      = 8'h99;
        rx_done_tick = 1'b1;
        tx_done_tick = 1'b1;
        @(negedge clk);
        check("same_tx_start", tx_start, 0);
        check("same_busy", busy, 0);
        check("same_alu_a", alu_a, 8'h80);
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-SEND.
        send_seq(8'h07, 8'h02, 8'h22, 8'h05);
        wait_tx_start();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_tx_start", tx_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_alu_a", alu_a, 0);
        check("post_rst_alu_b", alu_b, 0);
        check("post_rst_alu_op", alu_op, 0);
        check("post_rst_tx_data", tx_data, 0);
        check("post_rst_tx_start", tx_start, 0);

        send_seq(8'h03, 8'h04, 8'h20, 8'h07);
        serve_tx(2);

        repeat (3) @(negedge clk);
        check("frame_count", frames, exp_frames);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
